// File: rtl/rf_pkg.sv
// Shared register-file types and sizes for the writeback arbiter slice.
package rf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned NREG     = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  // One-hot decode of a register address onto the scoreboard vector.
  function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: per-source valid/ready plus packed rd and data lanes.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  import rf_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;

  modport master (output req_valid, output req_rd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rd, input req_data, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant_c,
  output logic [PW-1:0]   win_c,
  output logic            hs_c
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;

  // Scan from ptr upward, wrapping at NREQ; first valid source wins.
  always_comb begin
    grant_c = '0;
    win_c   = '0;
    hs_c    = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (!hs_c && valid[idx]) begin
        grant_c[idx] = 1'b1;
        win_c        = idx;
        hs_c         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs_c) begin
      ptr <= (win_c == PW'(NREQ - 1)) ? '0 : win_c + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with registered write stage and busy scoreboard.
// Define WB_FORWARD_EN to expose rs1_fwd/rs2_fwd and mask busy on the commit cycle.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  output logic                  write,
  output reg_addr_t             rd,
  output xword_t                rddata,
  input  logic                  resv_valid,
  input  reg_addr_t             resv_rd,
  input  reg_addr_t             rs1,
  input  reg_addr_t             rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [NREG-1:0]       busy_vec,
  output logic                  err
`ifdef WB_FORWARD_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam reg_addr_t   X0 = reg_addr_t'(ZERO_REG);

  logic [PW-1:0]   win_idx;
  logic            hs;
  reg_addr_t       win_rd;
  xword_t          win_data;
  logic            resv_act;
  logic            dbl_resv;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .grant_c (bus.req_ready),
    .win_c   (win_idx),
    .hs_c    (hs)
  );

  // One-hot grant selects the winner's rd/data lanes.
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      win_rd   = win_rd   | ({AW{bus.req_ready[i]}}   & bus.req_rd[i*AW +: AW]);
      win_data = win_data | ({XLEN{bus.req_ready[i]}} & bus.req_data[i*XLEN +: XLEN]);
    end
  end

  // x0 writes are accepted but never drive the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write  <= 1'b0;
      rd     <= '0;
      rddata <= '0;
    end else begin
      write <= hs && (win_rd != X0);
      if (hs) begin
        rd     <= win_rd;
        rddata <= win_data;
      end
    end
  end

  // Reservation wins over a same-edge commit to the same register.
  always_comb begin
    resv_act = resv_valid && (resv_rd != X0);
    set_vec  = resv_act ? reg_onehot(resv_rd) : '0;
    clr_vec  = write ? reg_onehot(rd) : '0;
    busy_nxt = ((busy_vec & ~clr_vec) | set_vec) & ~reg_onehot(X0);
    dbl_resv = resv_act && busy_vec[resv_rd] && !(write && (rd == resv_rd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      err      <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      if (dbl_resv) begin
        err <= 1'b1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign rs1_fwd  = write && (rd == rs1) && (rs1 != X0);
  assign rs2_fwd  = write && (rd == rs2) && (rs2 != X0);
  assign rs1_busy = busy_vec[rs1] && !rs1_fwd;
  assign rs2_busy = busy_vec[rs2] && !rs2_fwd;
`else
  assign rs1_busy = busy_vec[rs1];
  assign rs2_busy = busy_vec[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; writebacks checked against an expectation queue.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned N = 3;

  typedef struct packed {
    reg_addr_t rd;
    xword_t    data;
  } wb_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            write;
  reg_addr_t       rd;
  xword_t          rddata;
  logic            resv_valid;
  reg_addr_t       resv_rd;
  reg_addr_t       rs1;
  reg_addr_t       rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [NREG-1:0] busy_vec;
  logic            err;
`ifdef WB_FORWARD_EN
  logic            rs1_fwd;
  logic            rs2_fwd;
`endif

  int  checks   = 0;
  int  failures = 0;
  wb_t expq[$];

  regfile_wb_arbiter_if #(.NREQ(N)) bus ();

  regfile_wb_arbiter #(.NREQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .write      (write),
    .rd         (rd),
    .rddata     (rddata),
    .resv_valid (resv_valid),
    .resv_rd    (resv_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .busy_vec   (busy_vec),
    .err        (err)
`ifdef WB_FORWARD_EN
    ,
    .rs1_fwd    (rs1_fwd),
    .rs2_fwd    (rs2_fwd)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int unsigned s, input reg_addr_t r, input xword_t d);
    bus.req_rd[s*AW +: AW]       = r;
    bus.req_data[s*XLEN +: XLEN] = d;
  endtask

  task automatic push(input reg_addr_t r, input xword_t d);
    wb_t e;
    e.rd   = r;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic reserve(input reg_addr_t r);
    resv_valid = 1'b1;
    resv_rd    = r;
    tick();
    resv_valid = 1'b0;
  endtask

  function automatic xword_t mk(input int unsigned s, input int unsigned k);
    return 32'hA000_0000 | xword_t'(s << 8) | xword_t'(k);
  endfunction

  // Every committed write must match the oldest outstanding expectation.
  task automatic monitor();
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst && write) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 64'(write), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("wb_rd", 64'(rd), 64'(e.rd));
          chk("wb_data", 64'(rddata), 64'(e.data));
        end
      end
    end
  endtask

  initial begin
    int unsigned k[N];
    int unsigned ord[6];
    reg_addr_t   exp_rd[6];
    xword_t      exp_dat[6];
    logic [N-1:0] oh;

    ord     = '{0, 1, 2, 0, 1, 2};
    exp_rd  = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11, 5'd12};
    exp_dat = '{32'hA000_0000, 32'hA000_0100, 32'hA000_0200,
                32'hA000_0001, 32'hA000_0101, 32'hA000_0201};
    k       = '{0, 0, 0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    resv_valid    = 1'b0;
    resv_rd       = '0;
    rs1           = '0;
    rs2           = '0;
    fork
      monitor();
    join_none

    tick();
    tick();
    @(negedge clk);
    chk("rst_write", 64'(write), 64'(0));
    chk("rst_rd", 64'(rd), 64'(0));
    chk("rst_rddata", 64'(rddata), 64'(0));
    chk("rst_busy", 64'(busy_vec), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("idle_ready", 64'(bus.req_ready), 64'(0));
    tick();
    rst = 1'b0;

    // All three sources valid back to back from reset.
    for (int unsigned s = 0; s < N; s++) src(s, reg_addr_t'(10 + s), mk(s, 0));
    bus.req_valid = 3'b111;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      oh = 3'b001 << ord[j];
      chk("rr_grant", 64'(bus.req_ready), 64'(oh));
      if (j > 0) chk("sustained_write", 64'(write), 64'(1));
      push(exp_rd[j], exp_dat[j]);
      tick();
      k[ord[j]]++;
      src(ord[j], reg_addr_t'(10 + ord[j]), mk(ord[j], k[ord[j]]));
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("last_write", 64'(write), 64'(1));
    tick();

    // Reserve x5, then retire it through source 1.
    reserve(5'd5);
    rs1 = 5'd5;
    @(negedge clk);
    chk("busy5_set", 64'(busy_vec[5]), 64'(1));
    chk("rs1_busy5", 64'(rs1_busy), 64'(1));
    tick();
    src(1, 5'd5, 32'hDEAD_BEEF);
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("grant_src1", 64'(bus.req_ready), 64'(3'b010));
    push(5'd5, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("commit_write5", 64'(write), 64'(1));
    chk("busy5_pre_commit", 64'(busy_vec[5]), 64'(1));
    tick();
    @(negedge clk);
    chk("busy5_cleared", 64'(busy_vec[5]), 64'(0));
    chk("rs1_free5", 64'(rs1_busy), 64'(0));
    tick();

    // Re-reserve x7 on the same edge its write commits.
    reserve(5'd7);
    src(0, 5'd7, 32'h0000_0777);
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("grant_src0", 64'(bus.req_ready), 64'(3'b001));
    push(5'd7, 32'h0000_0777);
    tick();
    bus.req_valid = '0;
    resv_valid    = 1'b1;
    resv_rd       = 5'd7;
    @(negedge clk);
    chk("commit_write7", 64'(write), 64'(1));
    tick();
    resv_valid = 1'b0;
    @(negedge clk);
    chk("busy7_set_wins", 64'(busy_vec[7]), 64'(1));
    chk("err_same_edge", 64'(err), 64'(0));
    tick();

    // Write to x0 from source 2: granted, pointer advances, no write.
    src(2, 5'd0, 32'h1234_5678);
    bus.req_valid = 3'b100;
    @(negedge clk);
    chk("grant_x0", 64'(bus.req_ready), 64'(3'b100));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("x0_no_write", 64'(write), 64'(0));
    tick();
    src(0, 5'd12, 32'h0000_C0C0);
    src(1, 5'd13, 32'h0000_C1C1);
    bus.req_valid = 3'b011;
    @(negedge clk);
    chk("x0_ptr_adv", 64'(bus.req_ready), 64'(3'b001));
    push(5'd12, 32'h0000_C0C0);
    tick();
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("held_src1", 64'(bus.req_ready), 64'(3'b010));
    push(5'd13, 32'h0000_C1C1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    tick();

    // Reserving x0 is ignored; reserving x9 twice is an error.
    reserve(5'd0);
    @(negedge clk);
    chk("resv_x0", 64'(busy_vec), 64'(32'h0000_0080));
    tick();
    reserve(5'd9);
    @(negedge clk);
    chk("err_single_resv", 64'(err), 64'(0));
    tick();
    reserve(5'd9);
    @(negedge clk);
    chk("err_double", 64'(err), 64'(1));
    chk("busy_7_9", 64'(busy_vec), 64'(32'h0000_0280));
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'(1));
    tick();

    // Commit cycle of a write to a busy x3 read on rs2.
    reserve(5'd3);
    src(2, 5'd3, 32'h0000_0033);
    bus.req_valid = 3'b100;
    @(negedge clk);
    chk("grant_src2", 64'(bus.req_ready), 64'(3'b100));
    push(5'd3, 32'h0000_0033);
    tick();
    bus.req_valid = '0;
    rs2           = 5'd3;
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("rs2_busy_fwd", 64'(rs2_busy), 64'(0));
    chk("rs2_fwd", 64'(rs2_fwd), 64'(1));
    chk("rs1_fwd_x0", 64'(rs1_fwd), 64'(0));
`else
    chk("rs2_busy_commit", 64'(rs2_busy), 64'(1));
`endif
    tick();
    @(negedge clk);
    chk("rs2_after_commit", 64'(rs2_busy), 64'(0));
    tick();

    // Reset in the cycle after a handshake drops the pending write.
    src(0, 5'd20, 32'h0000_AAAA);
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("grant_pre_rst", 64'(bus.req_ready), 64'(3'b001));
    tick();
    bus.req_valid = '0;
    rst           = 1'b1;
    #1;
    chk("midrst_write", 64'(write), 64'(0));
    chk("midrst_rd", 64'(rd), 64'(0));
    chk("midrst_rddata", 64'(rddata), 64'(0));
    chk("midrst_busy", 64'(busy_vec), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    tick();
    rst = 1'b0;
    src(0, 5'd21, 32'h0000_0021);
    src(1, 5'd22, 32'h0000_0022);
    bus.req_valid = 3'b011;
    @(negedge clk);
    chk("ptr_reset", 64'(bus.req_ready), 64'(3'b001));
    chk("no_commit_after_rst", 64'(write), 64'(0));
    push(5'd21, 32'h0000_0021);
    tick();
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("post_rst_src1", 64'(bus.req_ready), 64'(3'b010));
    push(5'd22, 32'h0000_0022);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("final_idle", 64'(write), 64'(0));
    chk("queue_drained", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
